// File: rtl/bounce_sprite_engine_pkg.sv
// rtl/bounce_sprite_engine_pkg.sv - shared encodings and defaults for the bounce sprite engine
package bounce_sprite_engine_pkg;

  // dir[1]=1 moving left, dir[0]=1 moving down
  localparam logic [1:0] DIR_RIGHT_UP   = 2'b00;
  localparam logic [1:0] DIR_RIGHT_DOWN = 2'b01;
  localparam logic [1:0] DIR_LEFT_UP    = 2'b10;
  localparam logic [1:0] DIR_LEFT_DOWN  = 2'b11;
  localparam int DIR_LEFT_BIT = 1;
  localparam int DIR_DOWN_BIT = 0;

  localparam int DEF_SCRN_WIDTH  = 1024;
  localparam int DEF_SCRN_HEIGHT = 768;

  typedef enum logic {
    SERVE = 1'b0,
    RUN   = 1'b1
  } state_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/bounce_sprite_engine_vsync_edge_sync.sv
// rtl/bounce_sprite_engine_vsync_edge_sync.sv - vsync synchroniser with one-cycle falling-edge tick
module vsync_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  output logic fall_tick
);

  logic meta, sync, prev;

  // Registered tick lands three clocks after the raw falling edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta      <= 1'b0;
      sync      <= 1'b0;
      prev      <= 1'b0;
      fall_tick <= 1'b0;
    end else begin
      meta      <= vsync;
      sync      <= meta;
      prev      <= sync;
      fall_tick <= prev & ~sync;
    end
  end

endmodule

// File: rtl/bounce_sprite_engine.sv
// rtl/bounce_sprite_engine.sv - bouncing sprite with serve sequence, bounce events and box render
module bounce_sprite_engine
  import bounce_sprite_engine_pkg::*;
#(
  parameter int          SCRN_WIDTH   = DEF_SCRN_WIDTH,
  parameter int          SCRN_HEIGHT  = DEF_SCRN_HEIGHT,
  parameter int          OBJ_W        = 110,
  parameter int          OBJ_H        = 59,
  parameter int          MARGIN       = 10,
  parameter int          SPD_W        = 4,
  parameter int          SERVE_FRAMES = 60,
  parameter logic [1:0]  INIT_DIR     = DIR_RIGHT_UP,
  parameter logic [23:0] OBJ_COLOR    = 24'hFF_FF_FF
) (
  input  logic             vclock,
  input  logic             reset,
  input  logic             vsync,
  input  logic             enabled,
  input  logic             launch,
  input  logic [SPD_W-1:0] x_speed,
  input  logic [SPD_W-1:0] y_speed,
  input  logic [10:0]      hcount,
  input  logic [9:0]       vcount,
  output logic [10:0]      x_pos,
  output logic [9:0]       y_pos,
  output logic [1:0]       dir,
  output logic             serving,
  output logic             frame_tick,
  output logic             bounce_x,
  output logic             bounce_y,
  output logic [15:0]      bounce_count,
  output logic             in_obj,
  output logic [23:0]      pixel
);

  localparam int CW = $clog2(SERVE_FRAMES + 1);

  localparam logic [10:0] X_CENTRE = 11'((SCRN_WIDTH - OBJ_W) >> 1);
  localparam logic [9:0]  Y_CENTRE = 10'((SCRN_HEIGHT - OBJ_H) >> 1);
  localparam logic [10:0] X_MAX    = 11'(SCRN_WIDTH - MARGIN - OBJ_W);
  localparam logic [10:0] X_MIN    = 11'(MARGIN);
  localparam logic [9:0]  Y_MAX    = 10'(SCRN_HEIGHT - MARGIN - OBJ_H);
  localparam logic [9:0]  Y_MIN    = 10'(MARGIN);
  localparam logic [11:0] X_LIM    = 12'(SCRN_WIDTH - MARGIN);
  localparam logic [11:0] Y_LIM    = 12'(SCRN_HEIGHT - MARGIN);
  localparam logic [11:0] MARGIN12 = 12'(MARGIN);
  localparam logic [11:0] OBJ_W12  = 12'(OBJ_W);
  localparam logic [11:0] OBJ_H12  = 12'(OBJ_H);

  state_t        state, state_next;
  logic          armed;
  logic [CW-1:0] serve_cnt;
  logic          serve_done, step_en;

  logic [11:0] x_e, y_e, sx, sy;
  logic [10:0] x_next;
  logic [9:0]  y_next;
  logic        left_next, down_next, hit_x, hit_y;
  logic        in_obj_next;

  vsync_edge_sync u_vsync_edge_sync (
    .clk       (vclock),
    .reset     (reset),
    .vsync     (vsync),
    .fall_tick (frame_tick)
  );

  assign serve_done = armed && frame_tick && (serve_cnt == CW'(SERVE_FRAMES - 1));

  always_ff @(posedge vclock or posedge reset) begin
    if (reset) state <= SERVE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (launch) begin
      state_next = SERVE;
    end else begin
      case (state)
        SERVE:   if (serve_done) state_next = RUN;
        RUN:     state_next = RUN;
        default: state_next = SERVE;
      endcase
    end
  end

  always_comb begin
    serving = (state == SERVE);
    step_en = (state == RUN) && frame_tick && enabled && !launch;
  end

  // Widened to 12 bits so the limit compares never wrap
  assign x_e = {1'b0, x_pos};
  assign y_e = {2'b00, y_pos};
  assign sx  = 12'(x_speed);
  assign sy  = 12'(y_speed);

  always_comb begin
    x_next    = x_pos;
    left_next = dir[DIR_LEFT_BIT];
    hit_x     = 1'b0;
    if (sx != 12'd0) begin
      if (!dir[DIR_LEFT_BIT]) begin
        if (x_e + OBJ_W12 + sx >= X_LIM) begin
          x_next = X_MAX; left_next = 1'b1; hit_x = 1'b1;
        end else begin
          x_next = x_pos + 11'(x_speed);
        end
      end else begin
        if (x_e <= MARGIN12 + sx) begin
          x_next = X_MIN; left_next = 1'b0; hit_x = 1'b1;
        end else begin
          x_next = x_pos - 11'(x_speed);
        end
      end
    end
  end

  always_comb begin
    y_next    = y_pos;
    down_next = dir[DIR_DOWN_BIT];
    hit_y     = 1'b0;
    if (sy != 12'd0) begin
      if (dir[DIR_DOWN_BIT]) begin
        if (y_e + OBJ_H12 + sy >= Y_LIM) begin
          y_next = Y_MAX; down_next = 1'b0; hit_y = 1'b1;
        end else begin
          y_next = y_pos + 10'(y_speed);
        end
      end else begin
        if (y_e <= MARGIN12 + sy) begin
          y_next = Y_MIN; down_next = 1'b1; hit_y = 1'b1;
        end else begin
          y_next = y_pos - 10'(y_speed);
        end
      end
    end
  end

  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      x_pos        <= X_CENTRE;
      y_pos        <= Y_CENTRE;
      dir          <= INIT_DIR;
      armed        <= 1'b0;
      serve_cnt    <= '0;
      bounce_x     <= 1'b0;
      bounce_y     <= 1'b0;
      bounce_count <= 16'd0;
    end else begin
      bounce_x <= 1'b0;
      bounce_y <= 1'b0;
      if (launch) begin
        x_pos     <= X_CENTRE;
        y_pos     <= Y_CENTRE;
        dir       <= INIT_DIR;
        armed     <= 1'b1;
        serve_cnt <= '0;
      end else begin
        if (state == SERVE && armed && frame_tick) serve_cnt <= serve_cnt + CW'(1);
        if (step_en) begin
          x_pos        <= x_next;
          y_pos        <= y_next;
          dir          <= {left_next, down_next};
          bounce_x     <= hit_x;
          bounce_y     <= hit_y;
          bounce_count <= sat_add16(bounce_count, {1'b0, hit_x} + {1'b0, hit_y});
        end
      end
    end
  end

  assign in_obj_next = ({1'b0, hcount} >= x_e) && ({1'b0, hcount} < x_e + OBJ_W12) &&
                       ({2'b00, vcount} >= y_e) && ({2'b00, vcount} < y_e + OBJ_H12);

  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      in_obj <= 1'b0;
      pixel  <= 24'd0;
    end else begin
      in_obj <= in_obj_next;
      pixel  <= in_obj_next ? OBJ_COLOR : 24'd0;
    end
  end

endmodule

// File: tb/tb_bounce_sprite_engine.sv
// tb/tb_bounce_sprite_engine.sv - directed self-checking bench for bounce_sprite_engine
module tb_bounce_sprite_engine;

  logic        vclock = 1'b0;
  logic        reset;
  logic        vsync;
  logic        enabled;
  logic        launch;
  logic [3:0]  x_speed;
  logic [3:0]  y_speed;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [10:0] x_pos;
  logic [9:0]  y_pos;
  logic [1:0]  dir;
  logic        serving;
  logic        frame_tick;
  logic        bounce_x;
  logic        bounce_y;
  logic [15:0] bounce_count;
  logic        in_obj;
  logic [23:0] pixel;

  int total = 0;
  int passed = 0;
  int failed = 0;
  int bx_n, by_n, bx_sum, by_sum;
  int last_lat;
  int timeouts = 0;

  bounce_sprite_engine dut (
    .vclock(vclock), .reset(reset), .vsync(vsync), .enabled(enabled), .launch(launch),
    .x_speed(x_speed), .y_speed(y_speed), .hcount(hcount), .vcount(vcount),
    .x_pos(x_pos), .y_pos(y_pos), .dir(dir), .serving(serving), .frame_tick(frame_tick),
    .bounce_x(bounce_x), .bounce_y(bounce_y), .bounce_count(bounce_count),
    .in_obj(in_obj), .pixel(pixel)
  );

  always #8 vclock = ~vclock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge vclock);
    bx_n += int'(bounce_x);
    by_n += int'(bounce_y);
  endtask

  // One vsync period; returns two cycles after the tick so any step result is visible
  task automatic frame();
    int lat;
    bit got;
    bx_n = 0; by_n = 0;
    vsync = 1'b1;
    repeat (4) cyc();
    vsync = 1'b0;
    lat = 0; got = 0;
    while (!got && lat < 8) begin
      cyc();
      lat++;
      if (frame_tick) got = 1;
    end
    last_lat = lat;
    if (!got) timeouts++;
    repeat (2) cyc();
    bx_sum += bx_n;
    by_sum += by_n;
  endtask

  task automatic pulse_launch();
    @(negedge vclock);
    launch = 1'b1;
    @(negedge vclock);
    launch = 1'b0;
  endtask

  task automatic probe(input logic [10:0] h, input logic [9:0] v);
    @(negedge vclock);
    hcount = h; vcount = v;
    @(negedge vclock);
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b1; enabled = 1'b1; launch = 1'b0;
    x_speed = 4'd0; y_speed = 4'd0; hcount = 11'd0; vcount = 10'd0;
    repeat (3) @(negedge vclock);
    chk("reset_x", 32'(x_pos), 32'd457);
    chk("reset_y", 32'(y_pos), 32'd354);
    chk("reset_dir", 32'(dir), 32'd0);
    chk("reset_serving", 32'(serving), 32'd1);
    chk("reset_pulses", {29'd0, frame_tick, bounce_x, bounce_y}, 32'd0);
    chk("reset_count", 32'(bounce_count), 32'd0);
    chk("reset_pixel", {7'd0, in_obj, pixel}, 32'd0);
    reset = 1'b0;

    // Without launch the engine must never leave SERVE
    x_speed = 4'd4; y_speed = 4'd4;
    repeat (61) frame();
    chk("tick_latency", 32'(last_lat), 32'd3);
    chk("no_launch_serving", 32'(serving), 32'd1);
    chk("no_launch_x", 32'(x_pos), 32'd457);

    pulse_launch();
    repeat (59) frame();
    chk("serve_59_serving", 32'(serving), 32'd1);
    frame();
    chk("serve_60_serving", 32'(serving), 32'd0);
    chk("serve_60_x", 32'(x_pos), 32'd457);
    frame();
    chk("run1_x", 32'(x_pos), 32'd461);
    chk("run1_y", 32'(y_pos), 32'd350);
    chk("run1_dir", 32'(dir), 32'd0);

    bx_sum = 0; by_sum = 0;
    for (int i = 0; i < 30; i++) begin
      x_speed = (i < 29) ? 4'd15 : 4'd4;
      y_speed = 4'd0;
      frame();
    end
    chk("walk_right_x", 32'(x_pos), 32'd900);
    chk("speed0_y_held", 32'(y_pos), 32'd350);
    chk("walk_right_no_bounce", 32'(bx_sum + by_sum), 32'd0);

    x_speed = 4'd5;
    frame();
    chk("right_bounce_x", 32'(x_pos), 32'd904);
    chk("right_bounce_dir", 32'(dir), 32'd2);
    chk("right_bounce_pulse", 32'(bx_n), 32'd1);
    chk("right_bounce_no_y", 32'(by_n), 32'd0);
    chk("right_bounce_count", 32'(bounce_count), 32'd1);

    bx_sum = 0; by_sum = 0;
    for (int i = 0; i < 60; i++) begin
      x_speed = (i < 59) ? 4'd15 : 4'd7;
      frame();
    end
    chk("walk_left_x", 32'(x_pos), 32'd12);
    chk("walk_left_no_bounce", 32'(bx_sum + by_sum), 32'd0);
    x_speed = 4'd3;
    frame();
    chk("left_bounce_x", 32'(x_pos), 32'd10);
    chk("left_bounce_dir", 32'(dir), 32'd0);
    chk("left_bounce_pulse", 32'(bx_n), 32'd1);
    chk("left_bounce_count", 32'(bounce_count), 32'd2);

    bx_sum = 0; by_sum = 0;
    for (int i = 0; i < 60; i++) begin
      x_speed = (i < 59) ? 4'd15 : 4'd8;
      y_speed = (i < 22) ? 4'd15 : ((i == 22) ? 4'd9 : 4'd0);
      frame();
    end
    chk("pre_corner_x", 32'(x_pos), 32'd903);
    chk("pre_corner_y", 32'(y_pos), 32'd11);
    chk("pre_corner_no_bounce", 32'(bx_sum + by_sum), 32'd0);
    x_speed = 4'd1; y_speed = 4'd1;
    frame();
    chk("corner_x", 32'(x_pos), 32'd904);
    chk("corner_y", 32'(y_pos), 32'd10);
    chk("corner_dir", 32'(dir), 32'd3);
    chk("corner_pulses", 32'(bx_n * 10 + by_n), 32'd11);
    chk("corner_count", 32'(bounce_count), 32'd4);

    probe(11'd904, 10'd10);
    chk("render_tl", {7'd0, in_obj, pixel}, 32'h01FF_FFFF);
    probe(11'd1013, 10'd68);
    chk("render_br", {7'd0, in_obj, pixel}, 32'h01FF_FFFF);
    probe(11'd1014, 10'd68);
    chk("render_right_out", {7'd0, in_obj, pixel}, 32'd0);
    probe(11'd1000, 10'd69);
    chk("render_below_out", {7'd0, in_obj, pixel}, 32'd0);
    probe(11'd903, 10'd30);
    chk("render_left_out", {7'd0, in_obj, pixel}, 32'd0);

    enabled = 1'b0; x_speed = 4'd15; y_speed = 4'd15;
    bx_sum = 0; by_sum = 0;
    repeat (5) frame();
    chk("frozen_xy", {5'd0, x_pos, 6'd0, y_pos}, {5'd0, 11'd904, 6'd0, 10'd10});
    chk("frozen_dir", 32'(dir), 32'd3);
    chk("frozen_count", 32'(bounce_count), 32'd4);
    chk("frozen_no_pulses", 32'(bx_sum + by_sum), 32'd0);
    enabled = 1'b1;

    pulse_launch();
    chk("relaunch_serving", 32'(serving), 32'd1);
    chk("relaunch_xy", {5'd0, x_pos, 6'd0, y_pos}, {5'd0, 11'd457, 6'd0, 10'd354});
    chk("relaunch_dir", 32'(dir), 32'd0);

    probe(11'd457, 10'd354);
    chk("render_centre_tl", {7'd0, in_obj, pixel}, 32'h01FF_FFFF);
    probe(11'd567, 10'd354);
    chk("render_centre_right_out", {7'd0, in_obj, pixel}, 32'd0);
    probe(11'd566, 10'd412);
    chk("render_centre_br", {7'd0, in_obj, pixel}, 32'h01FF_FFFF);

    #3 reset = 1'b1;
    #1;
    chk("async_reset_pixel", {7'd0, in_obj, pixel}, 32'd0);
    chk("async_reset_serving", 32'(serving), 32'd1);
    chk("frame_timeouts", 32'(timeouts), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bounce_sprite_engine.md
Name: bounce_sprite_engine

Overview:
- Parametrised successor to the single-puck mover: one bouncing rectangular sprite with independent X/Y speeds, a serve/launch state machine and bounce event reporting.
- Frame stepping is driven by a vsync falling edge synchronised into the vclock domain, so everything runs on one clock.
- Emits a registered box-rendered pixel for the video mixer and position/event outputs for game logic (scoring, sound).

Parameters:
SCRN_WIDTH, 1024, active pixels per line
SCRN_HEIGHT, 768, active lines per frame
OBJ_W, 110, sprite width in pixels
OBJ_H, 59, sprite height in pixels
MARGIN, 10, bounce border in pixels on every edge
SPD_W, 4, width of the speed inputs
SERVE_FRAMES, 60, frame ticks held centred after launch before motion starts
INIT_DIR, 2'b00, direction after reset/serve; bit1=1 moving left, bit0=1 moving down
OBJ_COLOR, 24'hFF_FF_FF, RGB of the rendered box

Ports:
vclock  in  1  65 MHz pixel clock
reset  in  1  asynchronous, active-high
vsync  in  1  raw vsync, asynchronous to vclock logic
enabled  in  1  1 = motion allowed in RUN; 0 = freeze in place
launch  in  1  one-cycle pulse; (re)starts the serve sequence
x_speed  in  SPD_W  pixels per frame, horizontal
y_speed  in  SPD_W  pixels per frame, vertical
hcount  in  11  current pixel column
vcount  in  10  current pixel line
x_pos  out  11  sprite left edge
y_pos  out  10  sprite top edge
dir  out  2  current direction, encoding as INIT_DIR
serving  out  1  high in SERVE state
frame_tick  out  1  one-cycle pulse per vsync falling edge
bounce_x  out  1  one-cycle pulse on left/right reflection
bounce_y  out  1  one-cycle pulse on top/bottom reflection
bounce_count  out  16  total reflections, saturating at 16'hFFFF
in_obj  out  1  registered: current pixel inside sprite
pixel  out  24  registered: OBJ_COLOR inside sprite, else 0

Behaviour:
- Reset (async): x_pos=(SCRN_WIDTH-OBJ_W)>>1, y_pos=(SCRN_HEIGHT-OBJ_H)>>1, dir=INIT_DIR, state=SERVE with serve counter=0 (not armed), serving=1, all pulses 0, bounce_count=0, in_obj=0, pixel=0.
- vsync passes through a 2-flop synchroniser plus an edge register. frame_tick=1 for exactly one cycle on synchronised 1->0. Latency is 3 vclocks from the raw edge.
- States:
  - SERVE: position held at centre, dir=INIT_DIR. launch arms the counter from 0. Each frame_tick while armed increments it. When the counter reaches SERVE_FRAMES on a tick, go to RUN on the next cycle. If launch is never seen, stay in SERVE.
  - RUN: motion occurs on frame_tick only when enabled=1.
  - launch in any state: go to SERVE, recentre, set dir=INIT_DIR, re-arm counter=0. Pulses are suppressed that cycle.
- Speeds are sampled only on the frame_tick cycle. Speed 0 on an axis means no motion and no bounce on that axis.
- X step (sx=x_speed), computed at ≥12-bit width with no wrap:
  - Moving right: if x+OBJ_W+sx >= SCRN_WIDTH-MARGIN, then x<=SCRN_WIDTH-MARGIN-OBJ_W, dir[1]<=1, bounce_x pulses. Otherwise x<=x+sx.
  - Moving left: if x <= MARGIN+sx, then x<=MARGIN, dir[1]<=0, bounce_x pulses. Otherwise x<=x-sx.
- Y step: same rules with y_speed, OBJ_H, SCRN_HEIGHT, dir[0] (0=up), bounce_y.
- Corner (both axes reflect on one tick): bounce_x and bounce_y pulse together; bounce_count increments by 2, saturating.
- enabled=0 in RUN: position, dir and count all frozen; no pulses.
- Render path, 1-cycle latency from hcount/vcount:
  - in_obj <= (x_pos <= hcount < x_pos+OBJ_W) && (y_pos <= vcount < y_pos+OBJ_H).
  - pixel <= in_obj_next ? OBJ_COLOR : 0.
- Position updates only on frame_tick. Since vsync falls during vertical blank, no tearing occurs.

Decomposition:
- Shared package: direction encoding constants (DIR_RIGHT_UP=2'b00 etc.), state enum {SERVE, RUN}, default screen geometry constants.
- One natural sub-module: vsync_edge_sync (2-flop sync + falling-edge pulse). It is reused by other frame-stepped blocks.

Test Plan:
- Reset, launch, 60 vsync falls, enabled=1, speeds 4/4 -> serving drops after the 60th tick; first RUN tick moves to x=461, y=350 (dir 00: x+4, y-4).
- Sprite at x=900 moving right, sx=5 -> 900+110+5=1015>=1014, so x=904, dir[1]=1, bounce_x one cycle, count=1.
- Sprite at x=12 moving left, sx=3 -> 12<=13, so x=10, dir[1]=0, bounce_x pulses.
- Corner: x=904 moving right, y=10 moving up, speeds 1/1 -> bounce_x and bounce_y on the same cycle, dir=2'b11, count +2.
- enabled=0 across 5 ticks -> x/y/dir/count unchanged, no pulses. launch mid-RUN -> centre (457,354), serving=1 next cycle.
- Render: x=100, y=200, hcount=100..209 on vcount=200 -> in_obj/pixel=OBJ_COLOR exactly one cycle after each sample, 0 at hcount=210. Async reset mid-frame clears pixel immediately.
